// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and width helper for the debounce bank
package debounce_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RPT = 2'd2} rpt_state_e;
  function automatic int cw(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel with synchroniser, tick debounce and typematic repeat
module debounce_chan
  import debounce_pkg::*;
#(
  parameter logic ACT_LOW      = 1'b0,
  parameter int   DB_TICKS     = 3,
  parameter int   HOLD_TICKS   = 500,
  parameter int   REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic i_btn,
  output logic o_state,
  output logic o_ondn,
  output logic o_onup,
  output logic o_repeat
);
  localparam int DW = cw(DB_TICKS);
  localparam int RW = cw(HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS);
  logic sync1_q, sync2_q, raw, flip;
  logic state_q, state_d, ondn_q, ondn_d, onup_q, onup_d, rpt_q, rpt_d;
  logic [DW-1:0] db_q, db_d;
  logic [RW-1:0] rc_q, rc_d, lim;
  rpt_state_e fsm_q, fsm_d;
  assign raw  = sync2_q ^ ACT_LOW;
  assign flip = (raw != state_q) && tick && (db_q == DW'(DB_TICKS - 1));
  always_comb begin
    db_d    = (raw == state_q || flip) ? '0 : db_q + DW'(tick);
    state_d = state_q ^ flip;
    ondn_d  = flip & ~state_q;
    onup_d  = flip & state_q;
  end
  // Release wins over a repeat expiring on the same tick
  always_comb begin
    fsm_d = fsm_q;
    rc_d  = rc_q;
    rpt_d = 1'b0;
    lim   = (fsm_q == HOLD) ? RW'(HOLD_TICKS - 1) : RW'(REPEAT_TICKS - 1);
    case (fsm_q)
      IDLE: begin
        fsm_d = (ondn_d && HOLD_TICKS != 0) ? HOLD : IDLE;
        rc_d  = '0;
      end
      HOLD, RPT: begin
        if (onup_d) begin
          fsm_d = IDLE;
          rc_d  = '0;
        end else if (tick && rc_q == lim) begin
          fsm_d = RPT;
          rc_d  = '0;
          rpt_d = 1'b1;
        end else begin
          rc_d = rc_q + RW'(tick);
        end
      end
      default: begin
        fsm_d = IDLE;
        rc_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= ACT_LOW;
      sync2_q <= ACT_LOW;
      state_q <= 1'b0;
      ondn_q  <= 1'b0;
      onup_q  <= 1'b0;
      rpt_q   <= 1'b0;
      db_q    <= '0;
      rc_q    <= '0;
      fsm_q   <= IDLE;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      ondn_q  <= ondn_d;
      onup_q  <= onup_d;
      rpt_q   <= rpt_d;
      db_q    <= db_d;
      rc_q    <= rc_d;
      fsm_q   <= fsm_d;
    end
  end
  assign o_state  = state_q;
  assign o_ondn   = ondn_q;
  assign o_onup   = onup_q;
  assign o_repeat = rpt_q;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: shared tick prescaler driving N independent debounce channels
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int             N            = 8,
  parameter logic [N-1:0]   ACTIVE_LOW   = {N{1'b0}},
  parameter int             TICK_DIV     = 50000,
  parameter int             DB_TICKS     = 3,
  parameter int             HOLD_TICKS   = 500,
  parameter int             REPEAT_TICKS = 100
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] i_btn,
  output logic [N-1:0] o_state,
  output logic [N-1:0] o_ondn,
  output logic [N-1:0] o_onup,
  output logic [N-1:0] o_repeat
);
  localparam int PW = cw(TICK_DIV - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic tick;
  assign tick = pre_q == PW'(TICK_DIV - 1);
  always_comb pre_d = tick ? '0 : pre_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!resetn) pre_q <= '0;
    else pre_q <= pre_d;
  end
  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .ACT_LOW     (ACTIVE_LOW[i]),
      .DB_TICKS    (DB_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .tick    (tick),
      .i_btn   (i_btn[i]),
      .o_state (o_state[i]),
      .o_ondn  (o_ondn[i]),
      .o_onup  (o_onup[i]),
      .o_repeat(o_repeat[i])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed and random checks of debounce_bank against a tick-arithmetic model
module tb_debounce_bank;
  localparam int N = 4, TD = 4, DB = 3, H = 5, R = 2;
  localparam logic [N-1:0] AL = 4'b0001;
  logic clk = 1'b0, resetn = 1'b0;
  logic [N-1:0] i_btn = AL;
  logic [N-1:0] o_state, o_ondn, o_onup, o_repeat;
  logic [N-1:0] z_state, z_ondn, z_onup, z_repeat;
  int n_cmp = 0, n_bad = 0;
  logic [N-1:0] cur = AL;
  logic rn = 1'b0;
  logic [N-1:0] s1m, s2m, e_state, e_ondn, e_onup, e_rep;
  int cyc, ntick;
  int mark[N], ptick[N];
  bit held[N];
  always #5 clk = ~clk;
  debounce_bank #(.N(N), .ACTIVE_LOW(AL), .TICK_DIV(TD), .DB_TICKS(DB),
                  .HOLD_TICKS(H), .REPEAT_TICKS(R)) dut (
    .clk(clk), .resetn(resetn), .i_btn(i_btn), .o_state(o_state),
    .o_ondn(o_ondn), .o_onup(o_onup), .o_repeat(o_repeat));
  debounce_bank #(.N(N), .ACTIVE_LOW(AL), .TICK_DIV(TD), .DB_TICKS(DB),
                  .HOLD_TICKS(0), .REPEAT_TICKS(R)) dut0 (
    .clk(clk), .resetn(resetn), .i_btn(i_btn), .o_state(z_state),
    .o_ondn(z_ondn), .o_onup(z_onup), .o_repeat(z_repeat));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    s1m = AL; s2m = AL; cyc = 0; ntick = 0;
    e_state = '0; e_ondn = '0; e_onup = '0; e_rep = '0;
    for (int c = 0; c < N; c++) begin mark[c] = 0; ptick[c] = 0; held[c] = 0; end
  endtask
  // A level is accepted once it has disagreed with the output across DB whole ticks
  task automatic model_edge();
    bit tk;
    int nt, d;
    logic [N-1:0] raw;
    tk = (cyc % TD) == TD - 1;
    nt = ntick + (tk ? 1 : 0);
    raw = s2m ^ AL;
    e_ondn = '0; e_onup = '0; e_rep = '0;
    for (int c = 0; c < N; c++) begin
      if (raw[c] == e_state[c]) mark[c] = nt;
      else if (tk && nt - mark[c] == DB) begin
        e_state[c] = raw[c];
        mark[c] = nt;
        if (raw[c]) begin e_ondn[c] = 1'b1; held[c] = 1; ptick[c] = nt; end
        else begin e_onup[c] = 1'b1; held[c] = 0; end
      end
      d = nt - ptick[c];
      if (held[c] && !e_ondn[c] && tk && d >= H && (d - H) % R == 0) e_rep[c] = 1'b1;
    end
    s2m = s1m; s1m = cur; cyc++; ntick = nt;
  endtask
  task automatic step();
    resetn = rn;
    i_btn = cur;
    if (!rn) model_reset(); else model_edge();
    @(posedge clk);
    #1;
    chk("state", o_state, e_state);
    chk("ondn", o_ondn, e_ondn);
    chk("onup", o_onup, e_onup);
    chk("repeat", o_repeat, e_rep);
    chk("h0_state", z_state, e_state);
    chk("h0_ondn", z_ondn, e_ondn);
    chk("h0_onup", z_onup, e_onup);
    chk("h0_repeat", z_repeat, '0);
  endtask
  task automatic wait_pulse(input int ch, input bit up, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if ((up ? o_onup[ch] : o_ondn[ch]) === 1'b1) begin lat = k; break; end
    end
  endtask
  initial begin
    int lat, cnt, nxt;
    model_reset();
    @(negedge clk);
    rn = 1'b0; cur = AL;
    for (int k = 0; k < 20; k++) step();
    rn = 1'b1; cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      cnt += $countones(o_state | o_ondn | o_onup | o_repeat);
    end
    chk("idle_quiet", cnt, 0);
    cur[1] = 1'b1;
    wait_pulse(1, 0, lat);
    chk("ondn1_lat_ok", lat >= 11 && lat <= 14, 1);
    chk("ondn1_state", o_state[1], 1'b1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin step(); cnt += o_ondn[1]; end
    chk("ondn1_single", cnt, 0);
    cur[1] = 1'b0;
    wait_pulse(1, 1, lat);
    chk("onup1_lat_ok", lat >= 11 && lat <= 14, 1);
    chk("onup1_state", o_state[1], 1'b0);
    for (int k = 0; k < 20; k++) step();
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      cur[2] = ((k / 3) % 2) == 0;
      step();
      cnt += o_ondn[2] + o_onup[2];
    end
    chk("bounce_quiet", cnt, 0);
    cur[2] = 1'b1;
    wait_pulse(2, 0, lat);
    chk("ondn2_lat_ok", lat >= 11 && lat <= 14, 1);
    cur[2] = 1'b0;
    wait_pulse(2, 1, lat);
    chk("onup2_seen", lat > 0, 1);
    cur[3] = 1'b1;
    wait_pulse(3, 0, lat);
    chk("ondn3_seen", lat > 0, 1);
    cnt = 0; nxt = 20;
    for (int t = 1; t <= 80; t++) begin
      step();
      if (o_repeat[3]) begin chk("rpt3_offset", t, nxt); nxt += 8; cnt++; end
    end
    chk("rpt3_count", cnt, 8);
    cur[3] = 1'b0;
    wait_pulse(3, 1, lat);
    chk("onup3_seen", lat > 0, 1);
    chk("onup3_no_rpt", o_repeat[3], 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(); cnt += o_repeat[3]; end
    chk("rpt3_after_rel", cnt, 0);
    cur[0] = 1'b0;
    wait_pulse(0, 0, lat);
    chk("ondn0_seen", lat > 0, 1);
    rn = 1'b0;
    step();
    chk("rst_state0", o_state[0], 1'b0);
    rn = 1'b1;
    wait_pulse(0, 0, lat);
    chk("ondn0_refire", lat >= 1 && lat <= 14, 1);
    cur[0] = 1'b1;
    for (int k = 0; k < 20; k++) step();
    cur[1] = 1'b1;
    cnt = 0; nxt = 0;
    for (int k = 0; k < 200; k++) begin step(); cnt += z_repeat[1]; nxt += o_repeat[1]; end
    chk("h0_no_repeat", cnt, 0);
    chk("h5_repeat_seen", nxt > 0, 1);
    cur[1] = 1'b0;
    for (int k = 0; k < 20; k++) step();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) cur[$urandom_range(0, N - 1)] ^= 1'b1;
      rn = ($urandom_range(0, 499) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
